// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    FN_MUL    = 3'd0,
    FN_MULH   = 3'd1,
    FN_MULHSU = 3'd2,
    FN_MULHU  = 3'd3,
    FN_DIV    = 3'd4,
    FN_DIVU   = 3'd5,
    FN_REM    = 3'd6,
    FN_REMU   = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [XLEN_DEF-1:0] ALL_ONES = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] INT_MIN  = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/muldiv_step.sv
// One iteration over the 2*XLEN working register: shift-add for multiply,
// restoring subtract/shift for divide. Purely combinational.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] work_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] work_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, work_i[2*XLEN-1:XLEN]} + (work_i[0] ? {1'b0, operand_i} : '0);
    // Shifted partial remainder needs XLEN+1 bits; the top bit of diff is the borrow.
    diff   = work_i[2*XLEN-1:XLEN-1] - {1'b0, operand_i};
    work_o = '0;
    if (is_div_i) begin
      if (diff[XLEN]) work_o = {work_i[2*XLEN-2:0], 1'b0};
      else            work_o = {diff[XLEN-1:0], work_i[XLEN-2:0], 1'b1};
    end else begin
      work_o = {sum, work_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M mul/div sequencer: one bit per cycle (33 cycles accept->resp), special divides in 1.
// Result held in DONE until resp_ready; kill aborts silently. MULDIV_FAST_MUL_EN makes multiplies 1-cycle.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_func,
  input  logic [XLEN-1:0] req_opa,
  input  logic [XLEN-1:0] req_opb,
  input  logic            kill,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            stall
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_e            state_q;
  func_e             func_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q, rneg_q;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   resp_data_q;
  logic              resp_valid_q;

  func_e           req_f;
  logic            req_div, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  function automatic logic [XLEN-1:0] fixup(input func_e f, input logic neg, input logic rneg,
                                            input logic [2*XLEN-1:0] w);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg  ? -w : w;
    quo  = neg  ? -w[XLEN-1:0] : w[XLEN-1:0];
    rem  = rneg ? -w[2*XLEN-1:XLEN] : w[2*XLEN-1:XLEN];
    case (f)
      FN_MUL:                        fixup = prod[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU:  fixup = prod[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:               fixup = quo;
      default:                       fixup = rem;
    endcase
  endfunction

  always_comb begin
    req_f       = func_e'(req_func);
    req_div     = req_func[2];
    a_neg       = req_opa[XLEN-1] && (req_f inside {FN_MUL, FN_MULH, FN_MULHSU, FN_DIV, FN_REM});
    b_neg       = req_opb[XLEN-1] && (req_f inside {FN_MUL, FN_MULH, FN_DIV, FN_REM});
    mag_a       = a_neg ? -req_opa : req_opa;
    mag_b       = b_neg ? -req_opb : req_opb;
    div0        = req_div && (req_opb == '0);
    ovf         = (req_f == FN_DIV || req_f == FN_REM) && req_opa == INT_MIN && req_opb == ALL_ONES;
    // func bit 1 separates REM/REMU from DIV/DIVU
    special_res = div0 ? (req_func[1] ? req_opa : ALL_ONES) : (req_func[1] ? '0 : INT_MIN);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_w;
  assign fast_w = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i  (func_q[2]),
    .work_i    (work_q),
    .operand_i (opnd_q),
    .work_o    (work_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      func_q       <= FN_MUL;
      opnd_q       <= '0;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      work_q       <= '0;
      cnt_q        <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid && !kill) begin
          func_q <= req_f;
          neg_q  <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          cnt_q  <= '0;
          opnd_q <= req_div ? mag_b : mag_a;
          work_q <= {{XLEN{1'b0}}, (req_div ? mag_a : mag_b)};
          if (div0 || ovf) begin
            resp_data_q  <= special_res;
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!req_div) begin
            resp_data_q  <= fixup(req_f, a_neg ^ b_neg, a_neg, fast_w);
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
`endif
          else begin
            state_q <= S_CALC;
          end
        end
        S_CALC: if (kill) begin
          state_q <= S_IDLE;
        end else begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            resp_data_q  <= fixup(func_q, neg_q, rneg_q, work_d);
            resp_valid_q <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DONE: if (kill || resp_ready) begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:  stall = req_valid & ~kill;
      S_CALC:  stall = 1'b1;
      S_DONE:  stall = ~resp_ready;
      default: stall = 1'b0;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && !kill;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, corner sequences, random ops vs arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_func = 3'd0;
  logic [31:0] req_opa = '0;
  logic [31:0] req_opb = '0;
  logic        kill = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        stall;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func   (req_func),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'(a);
    ub  = longint'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 0;
    case (f)
      3'd0: p = sa * sb;
      3'd1: begin p = sa * sb; p = p >>> 32; end
      3'd2: begin p = sa * ub; p = p >>> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: if (b == 0) p = -1; else if (ovf) p = ua; else p = sa / sb;
      3'd5: if (b == 0) p = -1; else p = ua / ub;
      3'd6: if (b == 0) p = ua; else if (ovf) p = 0; else p = sa % sb;
      default: if (b == 0) p = ua; else p = ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f >= 3'd4 && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (f < 3'd4) return 1;
`endif
    return 33;
  endfunction

  // Called one time unit after a rising edge with the sequencer idle.
  // lat counts edges from the accept edge up to the first cycle resp_valid is high.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] d, output int lat);
    req_func  = f;
    req_opa   = a;
    req_opb   = b;
    req_valid = 1'b1;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    check("stall_on_req", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      check("stall_busy", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      lat++;
    end
    d = resp_data;
  endtask

  task automatic finish_op();
    @(posedge clk);
    #1;
    check("resp_valid_clear", 32'(resp_valid), 32'd0);
  endtask

  vec_t        vt[11];
  logic [31:0] d;
  int          lat;
  logic [2:0]  rf;
  logic [31:0] ra, rb;
  logic        seen;

  initial begin
    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vt[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vt[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vt[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vt[5]  = '{3'd5, 32'd100,        32'd7,         32'd14};
    vt[6]  = '{3'd7, 32'd100,        32'd7,         32'd2};
    vt[7]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vt[8]  = '{3'd6, 32'd5,          32'd0,         32'd5};
    vt[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vt[10] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000};

    #1;
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_data", resp_data, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_op(vt[i].f, vt[i].a, vt[i].b, d, lat);
      check($sformatf("vec%0d_data", i), d, vt[i].exp);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat(vt[i].f, vt[i].a, vt[i].b)));
      finish_op();
    end

    // kill on the 10th CALC cycle of a divide
    req_func = 3'd4; req_opa = 32'd1000; req_opb = 32'd7; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      seen |= resp_valid;
    end
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    #1;
    check("kill_req_ready", 32'(req_ready), 32'd1);
    check("kill_stall", 32'(stall), 32'd0);
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= resp_valid;
    end
    check("kill_no_resp", 32'(seen), 32'd0);
    do_op(3'd0, 32'd3, 32'd4, d, lat);
    check("after_kill_mul", d, 32'd12);
    finish_op();

    // kill in IDLE blocks acceptance of a 1-cycle special op
    kill = 1'b1; req_func = 3'd5; req_opa = 32'd5; req_opb = 32'd0; req_valid = 1'b1;
    #1;
    check("idle_kill_ready", 32'(req_ready), 32'd0);
    check("idle_kill_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    kill = 1'b0; req_valid = 1'b0;
    #1;
    check("idle_kill_not_acc", 32'(resp_valid), 32'd0);
    check("idle_kill_ready_after", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // backpressure in DONE
    resp_ready = 1'b0;
    do_op(3'd5, 32'd100, 32'd7, d, lat);
    check("bp_data", d, 32'd14);
    check("bp_lat", 32'(lat), 32'd33);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_valid_held", 32'(resp_valid), 32'd1);
      check("bp_data_held", resp_data, 32'd14);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_stall", 32'(stall), 32'd1);
    end
    resp_ready = 1'b1;
    #1;
    check("bp_stall_release", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    check("bp_valid_clear", 32'(resp_valid), 32'd0);
    check("bp_ready_back", 32'(req_ready), 32'd1);

    // kill in DONE drops the response
    resp_ready = 1'b0;
    do_op(3'd7, 32'd100, 32'd7, d, lat);
    check("done_kill_data", d, 32'd2);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("done_kill_valid", 32'(resp_valid), 32'd0);
    check("done_kill_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // asynchronous reset mid-CALC
    req_func = 3'd0; req_opa = 32'd5; req_opb = 32'd6; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_resp_data", resp_data, 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(3'd0, 32'd5, 32'd6, d, lat);
    check("arst_next_mul", d, 32'd30);
    finish_op();

    // randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 20);
        3: ra = -$urandom_range(0, 50);
        default: ;
      endcase
      do_op(rf, ra, rb, d, lat);
      check($sformatf("rnd%0d_f%0d_%h_%h_data", i, rf, ra, rb), d, ref_model(rf, ra, rb));
      check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(exp_lat(rf, ra, rb)));
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations (funct7 = 0000001), replacing single-cycle combinational mul/div in the execution path.
- Accepts one operation over a valid/ready handshake and iterates one result bit per cycle (shift-add multiply, restoring divide).
- Drives a stall line that holds the PC and register-file write until the result is delivered.
- Sits beside the execution unit; the core steers M-extension instructions to this block.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  block can accept a request.
- req_func  in  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 0..7.
- req_opa  in  XLEN  rs1 value.
- req_opb  in  XLEN  rs2 value.
- kill  in  1  abort the current operation (core flush/halt).
- resp_valid  out  1  result available.
- resp_ready  in  1  core consumes the result.
- resp_data  out  XLEN  result.
- stall  out  1  hold PC/RF write-enable.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, counter=0. Reset may arrive in any state; it discards any operation in flight.
- States are IDLE, CALC and DONE.
- IDLE:
  - req_ready=1.
  - Accept on req_valid & ~kill at a clock edge.
  - Latch func, operand magnitudes and sign flags.
  - Special cases go straight to DONE (latency 1):
    - divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
    - DIV/REM with 0x80000000 / 0xFFFFFFFF: DIV returns 0x80000000; REM returns 0.
  - All other operations go to CALC with counter=0.
- CALC:
  - One iteration per cycle.
  - Multiply: 64-bit product accumulator, add the multiplicand when the current multiplier LSB is 1, then shift.
  - Divide: restoring step over a 64-bit remainder:quotient register.
  - After XLEN iterations (counter==XLEN-1 at the edge), apply the sign fix-up and go to DONE.
  - Normal latency: accept edge + XLEN edges → resp_valid high in cycle N+XLEN+1 (33 cycles for XLEN=32).
- Signed rules:
  - MUL/MULH: both operands signed.
  - MULHSU: opa signed, opb unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL returns the low XLEN bits.
  - MULH* return the high XLEN bits.
- DONE:
  - resp_valid=1; resp_data is registered and held stable until resp_valid & resp_ready.
  - On the handshake, go to IDLE.
  - req_ready=0 in DONE; a back-to-back request is accepted only in the following IDLE cycle.
- kill:
  - In CALC or DONE: return to IDLE at the next edge, with no response and resp_valid=0.
  - In IDLE, kill blocks acceptance (req_ready=0 while kill=1).
  - kill has priority over req_valid and resp_ready.
- stall (combinational):
  - IDLE: req_valid & ~kill.
  - CALC: 1.
  - DONE: ~resp_ready.
- Unused func codes are impossible: all 8 codes are legal.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU compute combinationally from the latched operands and go IDLE→DONE (latency 1; resp_valid in the cycle after accept).
  - Divide is unchanged.
- Undefined: all multiplies take the XLEN-cycle shift-add path described above.

Decomposition:
- Package muldiv_pkg holds:
  - func encodings MUL..REMU.
  - state enum IDLE/CALC/DONE.
  - XLEN default.
  - special-case constants: ALL_ONES, INT_MIN.
- One natural sub-module, muldiv_step: the combinational single-iteration add/shift and subtract/restore for the 64-bit working register, selected by an is_div input.
- muldiv_sequencer holds the FSM, counter, sign latching and fix-up.

Test Plan:
- MUL, opa=7, opb=0xFFFFFFFD → resp_data=0xFFFFFFEB; resp_valid 33 cycles after accept; stall high every cycle until the resp handshake.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU opa=0xFFFFFFFF, opb=0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000. All three have resp_valid exactly 1 cycle after accept.
- Issue DIV, assert kill on CALC cycle 10 → resp_valid never rises; req_ready=1 next cycle; a new MUL 3×4 is accepted and returns 12.
- Hold resp_ready low 3 cycles in DONE → resp_valid/resp_data stable, req_ready=0, stall=1. Assert rst mid-CALC → all outputs return to reset values immediately (asynchronously).
